// File: rtl/datapath_sequencer.sv
// datapath_sequencer
// Microcoded controller for the register/ALU datapath. One accepted command
// runs R[dst] = R[src1] op R[src2]. An optional clear and an optional load of
// the M inputs can run first. The EXEC step repeats rep+1 times so that
// accumulate and shift chains run as a single command.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             command request, sampled only in IDLE
//   cmd_clr/cmd_load  optional pre-steps: clear all registers / load M0..M2
//   src1, src2, dst   register indices (source 3 selects constant 0; dst 3 is illegal)
//   op, rep, cin_in   ALU code, extra EXEC passes, carry-in for EXEC
//   busy, done, err   handshake and sticky illegal-destination flag
//   clr, w, ce, sel, s, cin  datapath control lines
//
// state  | meaning
// INIT   | reset state, datapath clear held
// IDLE   | waiting for start, command latched on accept
// CLEAR  | synchronous clear of all registers
// LOAD   | R0..R2 <= M0..M2
// FETCH  | A <= R[src1] through the ALU pass code
// EXEC   | A <= A op R[src2], repeated until counter is 0
// WRITE  | R[dst] <= A, or flag err when dst is 3
// DONE   | one-cycle completion pulse
module datapath_sequencer #(
   parameter logic [2:0] PASS_OP = 3'b000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cmd_clr,
   input  logic       cmd_load,
   input  logic [1:0] src1,
   input  logic [1:0] src2,
   input  logic [1:0] dst,
   input  logic [2:0] op,
   input  logic [2:0] rep,
   input  logic       cin_in,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       clr,
   output logic [2:0] w,
   output logic [3:0] ce,
   output logic [1:0] sel,
   output logic [2:0] s,
   output logic       cin
);

   typedef enum logic [2:0] {
      ST_INIT, ST_IDLE, ST_CLEAR, ST_LOAD, ST_FETCH, ST_EXEC, ST_WRITE, ST_DONE
   } state_t;

   state_t     state, state_nxt;
   logic       clr_q, load_q, cin_q;
   logic [1:0] src1_q, src2_q, dst_q;
   logic [2:0] op_q, rep_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_INIT;
         err     <= 1'b0;
         clr_q   <= 1'b0;
         load_q  <= 1'b0;
         cin_q   <= 1'b0;
         src1_q  <= 2'd0;
         src2_q  <= 2'd0;
         dst_q   <= 2'd0;
         op_q    <= 3'd0;
         rep_cnt <= 3'd0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && start) begin
            clr_q   <= cmd_clr;
            load_q  <= cmd_load;
            cin_q   <= cin_in;
            src1_q  <= src1;
            src2_q  <= src2;
            dst_q   <= dst;
            op_q    <= op;
            rep_cnt <= rep;
            err     <= 1'b0;
         end else begin
            // Counter only decrements while non-zero, so it cannot wrap.
            if (state == ST_EXEC && rep_cnt != 3'd0)
               rep_cnt <= rep_cnt - 3'd1;
            if (state == ST_WRITE && dst_q == 2'd3)
               err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      clr       = 1'b0;
      w         = 3'b000;
      ce        = 4'b0000;
      sel       = 2'd0;
      s         = 3'd0;
      cin       = 1'b0;
      unique case (state)
         ST_INIT: begin
            clr       = 1'b1;
            state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (start) begin
               if (cmd_clr)       state_nxt = ST_CLEAR;
               else if (cmd_load) state_nxt = ST_LOAD;
               else               state_nxt = ST_FETCH;
            end
         end
         ST_CLEAR: begin
            clr       = 1'b1;
            busy      = 1'b1;
            state_nxt = load_q ? ST_LOAD : ST_FETCH;
         end
         ST_LOAD: begin
            ce        = 4'b0111;
            busy      = 1'b1;
            state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            sel       = src1_q;
            s         = PASS_OP;
            ce        = 4'b1000;
            busy      = 1'b1;
            state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            sel  = src2_q;
            s    = op_q;
            cin  = cin_q;
            ce   = 4'b1000;
            busy = 1'b1;
            if (rep_cnt == 3'd0) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            busy = 1'b1;
            if (dst_q != 2'd3) begin
               w  = 3'b001 << dst_q;
               ce = {1'b0, 3'b001 << dst_q};
            end
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            busy      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

endmodule

// File: tb/tb_datapath_sequencer.sv
module tb_datapath_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, cmd_clr, cmd_load, cin_in;
   logic [1:0] src1, src2, dst;
   logic [2:0] op, rep;
   logic       busy, done, err, clr, cin;
   logic [2:0] w, s;
   logic [3:0] ce;
   logic [1:0] sel;

   int checks = 0;
   int errors = 0;
   logic [15:0] obs;

   datapath_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd_clr(cmd_clr),
      .cmd_load(cmd_load), .src1(src1), .src2(src2), .dst(dst), .op(op),
      .rep(rep), .cin_in(cin_in), .busy(busy), .done(done), .err(err),
      .clr(clr), .w(w), .ce(ce), .sel(sel), .s(s), .cin(cin)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pack(input logic b, input logic d, input logic c,
                                        input logic [2:0] wv, input logic [3:0] cev,
                                        input logic [1:0] sv, input logic [2:0] sa,
                                        input logic ci);
      return {b, d, c, wv, cev, sv, sa, ci};
   endfunction

   always_comb obs = {busy, done, clr, w, ce, sel, s, cin};

   // Reference: a command is the list of control words it must produce,
   // one per cycle, built from the command fields.
   task automatic run_cmd(input logic c_clr, input logic c_load,
                          input logic [1:0] s1, input logic [1:0] s2,
                          input logic [1:0] d, input logic [2:0] o,
                          input logic [2:0] r, input logic ci,
                          input bit hold, input bit disturb, input string name);
      logic [15:0] q[$];
      logic        exp_err;
      if (c_clr)  q.push_back(pack(1, 0, 1, 3'b000, 4'b0000, 2'd0, 3'd0, 0));
      if (c_load) q.push_back(pack(1, 0, 0, 3'b000, 4'b0111, 2'd0, 3'd0, 0));
      q.push_back(pack(1, 0, 0, 3'b000, 4'b1000, s1, 3'b000, 0));
      for (int k = 0; k <= int'(r); k++)
         q.push_back(pack(1, 0, 0, 3'b000, 4'b1000, s2, o, ci));
      if (d == 2'd3) q.push_back(pack(1, 0, 0, 3'b000, 4'b0000, 2'd0, 3'd0, 0));
      else           q.push_back(pack(1, 0, 0, 3'(1 << d), 4'(1 << d), 2'd0, 3'd0, 0));
      q.push_back(pack(1, 1, 0, 3'b000, 4'b0000, 2'd0, 3'd0, 0));

      cmd_clr = c_clr; cmd_load = c_load; src1 = s1; src2 = s2; dst = d;
      op = o; rep = r; cin_in = ci; start = 1'b1;
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         checks++;
         if (obs !== q[i]) begin
            errors++;
            $display("FAIL %s cycle %0d controls got %h expected %h", name, i, obs, q[i]);
         end
         exp_err = (i == q.size() - 1) && (d == 2'd3);
         checks++;
         if (err !== exp_err) begin
            errors++;
            $display("FAIL %s cycle %0d err got %b expected %b", name, i, err, exp_err);
         end
         if (disturb && i < q.size() - 1) begin
            start = 1'($urandom); cmd_clr = 1'($urandom); cmd_load = 1'($urandom);
            src1 = 2'($urandom); src2 = 2'($urandom); dst = 2'($urandom);
            op = 3'($urandom); rep = 3'($urandom); cin_in = 1'($urandom);
         end else if (!hold) begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      checks++;
      if (obs !== 16'h0) begin
         errors++;
         $display("FAIL %s idle controls got %h expected 0000", name, obs);
      end
      checks++;
      if (err !== (d == 2'd3)) begin
         errors++;
         $display("FAIL %s idle err got %b expected %b", name, err, d == 2'd3);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 0; cmd_clr = 0; cmd_load = 0; src1 = 0; src2 = 0;
      dst = 0; op = 0; rep = 0; cin_in = 0;
      #3;
      checks++;
      if (obs !== pack(0, 0, 1, 3'b000, 4'b0000, 2'd0, 3'd0, 0) || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold controls got %h err %b expected 2000 err 0", obs, err);
      end
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (clr !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release clr got %b busy %b expected clr 1 busy 0", clr, busy);
      end
      @(negedge clk);
      checks++;
      if (obs !== 16'h0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle controls got %h err %b expected 0000 err 0", obs, err);
      end
   endtask

   task automatic test_reset_mid;
      cmd_clr = 0; cmd_load = 0; src1 = 1; src2 = 2; dst = 0; op = 3'd5;
      rep = 3'd7; cin_in = 1; start = 1;
      @(negedge clk); start = 0;        // FETCH
      @(negedge clk);                   // EXEC
      checks++;
      if (ce !== 4'b1000) begin
         errors++;
         $display("FAIL reset_mid pre ce got %b expected 1000", ce);
      end
      @(posedge clk); #2 rst_n = 1'b0; #1;
      checks++;
      if (obs !== pack(0, 0, 1, 3'b000, 4'b0000, 2'd0, 3'd0, 0) || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid abort controls got %h err %b expected 2000 err 0", obs, err);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (clr !== 1'b1 || ce !== 4'b0000) begin
         errors++;
         $display("FAIL reset_mid init clr got %b ce %b expected 1 0000", clr, ce);
      end
      @(negedge clk);
      checks++;
      if (obs !== 16'h0) begin
         errors++;
         $display("FAIL reset_mid idle controls got %h expected 0000", obs);
      end
   endtask

   task automatic test_full_cmd;
      run_cmd(1, 1, 2'd0, 2'd1, 2'd2, 3'b001, 3'd0, 0, 0, 0, "full_cmd");
   endtask

   task automatic test_rep;
      run_cmd(0, 0, 2'd1, 2'd2, 2'd0, 3'b011, 3'd3, 1, 0, 0, "rep3");
      run_cmd(0, 1, 2'd2, 2'd0, 2'd1, 3'b110, 3'd7, 0, 0, 0, "rep7");
   endtask

   task automatic test_err;
      run_cmd(0, 0, 2'd0, 2'd1, 2'd3, 3'b010, 3'd1, 0, 0, 0, "dst3");
      run_cmd(0, 0, 2'd1, 2'd0, 2'd0, 3'b010, 3'd0, 0, 0, 0, "err_clear");
   endtask

   task automatic test_disturb;
      run_cmd(1, 0, 2'd2, 2'd1, 2'd1, 3'b100, 3'd4, 1, 0, 1, "disturb");
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== 16'h0) begin
         errors++;
         $display("FAIL no_second_cmd controls got %h expected 0000", obs);
      end
   endtask

   task automatic test_back_to_back;
      run_cmd(0, 0, 2'd3, 2'd1, 2'd0, 3'b001, 3'd0, 0, 1, 0, "b2b_0");
      run_cmd(0, 0, 2'd3, 2'd2, 2'd1, 3'b111, 3'd2, 1, 1, 0, "b2b_1");
      run_cmd(1, 1, 2'd3, 2'd3, 2'd2, 3'b000, 3'd1, 0, 1, 0, "b2b_2");
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random;
      for (int n = 0; n < 30; n++)
         run_cmd(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                 2'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                 0, bit'($urandom_range(0, 1)), "random");
   endtask

   initial begin
      test_reset;
      test_full_cmd;
      test_rep;
      test_err;
      test_disturb;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Microcoded controller that sequences the Lab 4 register/ALU datapath: generates CLR, W, CE, SEL, S and Cin so that one command runs the full operation R[DST] = R[SRC1] OP R[SRC2], with optional clear and external load first. It sits between the switch/command logic and the datapath and replaces hand-driven control lines with a START/BUSY/DONE handshake. The EXEC step can repeat (REP+1 passes) for accumulate or shift chains.

## Interface
- PASS_OP, default 3'b000: ALU S code that passes the B operand to the ALU output. Used in FETCH.
- CLK  in  1  rising-edge clock
- RST_N  in  1  reset, asynchronous assert, active-low
- START  in  1  command request; sampled only in IDLE
- CMD_CLR  in  1  command: clear all datapath registers first
- CMD_LOAD  in  1  command: load M0/M1/M2 into R0/R1/R2 first
- SRC1  in  2  first operand register index (3 selects constant 0)
- SRC2  in  2  second operand register index (3 selects constant 0)
- DST  in  2  destination register index (3 is illegal)
- OP  in  3  ALU code applied in EXEC
- REP  in  3  number of extra EXEC passes (0..7)
- CIN_IN  in  1  carry-in used during EXEC
- BUSY  out  1  command in progress
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  sticky illegal-DST flag, cleared by the next accepted START
- CLR  out  1  datapath synchronous clear
- W  out  3  datapath input mux selects (1 selects accumulator A)
- CE  out  4  register enables, CE[3] = accumulator
- SEL  out  2  B-operand mux select
- S  out  3  ALU operation
- CIN  out  1  ALU carry-in

## Operation
- States: INIT, IDLE, CLEAR, LOAD, FETCH, EXEC, WRITE, DONE. Moore outputs are decoded from the state register and the latched command. Every output not listed for a state is 0.
- INIT: CLR=1. This is the reset state. Next state is IDLE.
- IDLE: BUSY=0. If START=1, latch all command fields and REP into a 3-bit counter, and clear ERR. Next state is CLEAR if CMD_CLR, else LOAD if CMD_LOAD, else FETCH.
- CLEAR: CLR=1, BUSY=1. Next state is LOAD if CMD_LOAD, else FETCH.
- LOAD: W=000, CE=0111, BUSY=1. Next state is FETCH.
- FETCH: SEL=SRC1, S=PASS_OP, CE=1000, BUSY=1. Result: A <= R[SRC1]. Next state is EXEC.
- EXEC: SEL=SRC2, S=OP, CIN=CIN_IN (latched), CE=1000, BUSY=1. Result: A <= A OP R[SRC2].
  - If the counter is 0, go to WRITE.
  - Otherwise decrement the counter and stay in EXEC.
- WRITE: BUSY=1.
  - DST=0/1/2: W[DST]=1 and CE[DST]=1, so R[DST] <= A.
  - DST=3: W=000 and CE=0000 (no write), and ERR is set.
  - Next state is DONE.
- DONE: DONE=1, BUSY=1. Next state is IDLE.
- START outside IDLE is ignored; the command is not queued. Command inputs are not used after the IDLE latch, so changing them mid-command has no effect.

## Timing
- Reset (RST_N low, asynchronous) forces state INIT and ERR=0. During reset: CLR=1; BUSY, DONE, W, CE, SEL, S, CIN all 0.
- After RST_N rises, the first edge moves INIT to IDLE, so CLR is high for at least one full clock after release.
- Reset asserted mid-command aborts immediately: CE drops to 0 the same instant, no partial WRITE occurs, and the sequence restarts at INIT.
- START is sampled at an edge in IDLE; the first command state is active in the following cycle.
- Command length from the START edge to the DONE-cycle end is 4 + REP + CMD_CLR + CMD_LOAD cycles (minimum 4, maximum 13).
- DONE is high exactly one cycle, and BUSY falls on the edge after it. A START held high is accepted again in the cycle after DONE, because that cycle is IDLE.
- REP=7 gives 8 EXEC cycles. The counter never wraps.

## Test plan
- Reset: hold RST_N=0 mid-EXEC -> CE=0000 and CLR=1 at once. After release: CLR=1 for 1 cycle, then IDLE with all outputs 0.
- Full command CMD_CLR=1, CMD_LOAD=1, SRC1=0, SRC2=1, OP=3'b001, DST=2, REP=0 -> states CLEAR, LOAD, FETCH, EXEC, WRITE, DONE.
  - Expect CLR=1, then CE=0111/W=000, then SEL=00/S=000, then SEL=01/S=001, then W=100/CE=0100, then DONE=1.
  - Total is 6 cycles.
- REP=3, SRC2=2, CIN_IN=1 -> EXEC lasts exactly 4 cycles with SEL=10 and CIN=1. Latency is 7 cycles with no clear/load.
- DST=3 -> WRITE has CE=0000, ERR=1 after the WRITE edge, and DONE still pulses. The next START clears ERR.
- START pulsed during EXEC, and command inputs changed mid-command -> no effect on the current sequence, and no second command runs after DONE.
- SRC1=3 with START held high continuously -> FETCH drives SEL=11. Back-to-back commands have exactly one IDLE cycle between DONE and the next FETCH.
